ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  Parametrised EX->MEM pipeline stage register with valid/ready handshake and 2-entry skid buffer.
//  Sits between ALU/EX and data-memory/MEM; supports back-pressure from MEM and flush on redirect.
//  Bubbles never assert memory or register-file side-effect controls.
// PARAMETERS
//  DATA_W     32  width of PC, ALU result and store data fields
//  REG_ADDR_W 5   destination register index width
//  CTRL_W     7   control bundle width; bit map {Zero,Jump,RegWrite,MemWrite,MemToReg,MemRead,Branch} (bit6..0)
//  PC_RESET   1   reset value of mem_pc_next
//  CNT_W      16  perf counter width (EX_MEM_PERF_EN only)
// PORTS
//  clk            in   1           rising-edge clock
//  rst            in   1           async active-high reset
//  flush          in   1           sync squash of all held entries
//  ex_valid       in   1           EX presents an instruction
//  ex_ready       out  1           stage can accept this cycle
//  ex_pc_next     in   DATA_W      PC+4 from EX
//  ex_alu_result  in   DATA_W      ALU result / address
//  ex_rd2         in   DATA_W      store data (register read 2)
//  ex_ctrl        in   CTRL_W      control bundle
//  ex_wr_reg      in   REG_ADDR_W  destination register
//  mem_valid      out  1           output entry valid
//  mem_ready      in   1           MEM consumes entry this cycle
//  mem_pc_next, mem_alu_result, mem_rd2  out DATA_W   registered fields
//  mem_ctrl       out  CTRL_W      registered control, forced 0 when mem_valid=0
//  mem_wr_reg     out  REG_ADDR_W  registered destination register
//  stall_cnt      out  CNT_W       cycles with mem_valid & !mem_ready (EX_MEM_PERF_EN)
//  flush_cnt      out  CNT_W       entries discarded by flush (EX_MEM_PERF_EN)
// BEHAVIOUR
//  Reset (async, rst=1): main_v=skid_v=0; mem_pc_next=PC_RESET; all other data/ctrl/wr_reg=0; counters=0.
//  Storage: main reg (drives outputs) + skid reg. ex_ready = !skid_v (registered, no comb path from mem_ready).
//  Accept = ex_valid & ex_ready; Consume = mem_valid & mem_ready.
//  Latency 1 cycle EX->MEM; throughput 1/cycle while mem_ready=1.
//  Transitions (no flush), state {main_v,skid_v}:
//   EMPTY  {0,0}: accept -> main<=in, FULL1.
//   FULL1  {1,0}: consume&accept -> main<=in; consume only -> EMPTY;
//                 accept & !consume -> skid<=in, FULL2.
//   FULL2  {1,1}: ex_ready=0; consume -> main<=skid, skid_v<=0, FULL1.
//  Ordering strictly FIFO; no entry dropped or duplicated; skid never bypasses main.
//  flush=1: main_v<=0, skid_v<=0 next edge; a same-cycle accept is dropped; flush beats consume
//   (MEM may still sample the entry presented this cycle; producer must not count it as accepted).
//  mem_ctrl = main_v ? main_ctrl : 0, mem_valid = main_v; data fields hold last value when invalid.
//  Fields are captured as whole-entry; ex_wr_reg travels with its instruction like every other field.
//  rst asserted mid-operation discards all entries immediately, independent of clk.
// CONFIGURATION
//  EX_MEM_PERF_EN defined: stall_cnt +1 per cycle mem_valid&!mem_ready; flush_cnt += main_v+skid_v
//   on each flush cycle; both saturate at all-ones; cleared only by rst.
//  EX_MEM_PERF_EN undefined: counter logic not built; stall_cnt=flush_cnt=0 constant.
// TESTING
//  1 Stream: ex_valid=1, mem_ready=1, alu_result=0x10,0x14,0x18 -> same values on mem side 1 cycle later, ex_ready=1 throughout.
//  2 Back-pressure: 3 entries A,B,C with mem_ready=0 -> A on output, B in skid, ex_ready=0 after B, C held;
//    release mem_ready -> outputs A,B,C in order, no loss.
//  3 Flush in FULL2 with ex_valid=1 -> next cycle mem_valid=0, mem_ctrl=0, ex_ready=1; incoming entry absent;
//    flush_cnt=2 with EX_MEM_PERF_EN.
//  4 Bubble: ex_valid=0, ex_ctrl=7'h7F -> mem_ctrl=0 (no MemWrite/RegWrite leak).
//  5 Async reset mid-stream (rst pulse between edges) -> mem_valid=0, mem_pc_next=1 immediately, other outputs 0.
//  6 Perf: mem_ready=0 for 5 cycles with valid entry -> stall_cnt=5; counter at max stays at max.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: valid/ready handshake plus the instruction entry fields.
// master drives valid and the fields, slave drives ready.
interface ex_mem_stage_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CTRL_W     = 7
);
  logic                  valid;
  logic                  ready;
  logic [DATA_W-1:0]     pc_next;
  logic [DATA_W-1:0]     alu_result;
  logic [DATA_W-1:0]     rd2;
  logic [CTRL_W-1:0]     ctrl;
  logic [REG_ADDR_W-1:0] wr_reg;

  modport master (
    output valid, pc_next, alu_result, rd2, ctrl, wr_reg,
    input  ready
  );

  modport slave (
    input  valid, pc_next, alu_result, rd2, ctrl, wr_reg,
    output ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with 2-entry skid buffer, flush and bubble control masking.
// Optional perf counters (stall/flush) are built when EX_MEM_PERF_EN is defined.
module ex_mem_stage #(
  parameter int unsigned     DATA_W     = 32,
  parameter int unsigned     REG_ADDR_W = 5,
  parameter int unsigned     CTRL_W     = 7,
  parameter logic [DATA_W-1:0] PC_RESET = DATA_W'(1),
  parameter int unsigned     CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  ex_mem_stage_if.slave       ex_i,
  ex_mem_stage_if.master      mem_o,
  output logic [CNT_W-1:0]    stall_cnt_o,
  output logic [CNT_W-1:0]    flush_cnt_o
);

  typedef struct packed {
    logic [DATA_W-1:0]     pc_next;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     rd2;
    logic [CTRL_W-1:0]     ctrl;
    logic [REG_ADDR_W-1:0] wr_reg;
  } entry_t;

  localparam entry_t ResetEntry = '{
    pc_next:    PC_RESET,
    alu_result: '0,
    rd2:        '0,
    ctrl:       '0,
    wr_reg:     '0
  };

  // Encoding is {main_v, skid_v}.
  typedef enum logic [1:0] {
    StEmpty = 2'b00,
    StFull1 = 2'b10,
    StFull2 = 2'b11
  } state_e;

  state_e state_q, state_d;
  entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic   main_v, skid_v, accept, consume;
  logic   load_main_in, load_main_skid, load_skid;

  assign in_entry = '{
    pc_next:    ex_i.pc_next,
    alu_result: ex_i.alu_result,
    rd2:        ex_i.rd2,
    ctrl:       ex_i.ctrl,
    wr_reg:     ex_i.wr_reg
  };

  assign main_v     = (state_q != StEmpty);
  assign skid_v     = (state_q == StFull2);
  assign ex_i.ready = ~skid_v;
  assign accept     = ex_i.valid & ~skid_v;
  assign consume    = main_v & mem_o.ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: if (accept) state_d = StFull1;
        StFull1: begin
          if (consume && !accept)      state_d = StEmpty;
          else if (!consume && accept) state_d = StFull2;
        end
        StFull2: if (consume) state_d = StFull1;
        default: state_d = StEmpty;
      endcase
    end
  end

  // A flushed cycle loads nothing, so a same-cycle accept never lands in storage.
  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (!flush_i) begin
      unique case (state_q)
        StEmpty: load_main_in = accept;
        StFull1: begin
          load_main_in = accept & consume;
          load_skid    = accept & ~consume;
        end
        StFull2: load_main_skid = consume;
        default: ;
      endcase
    end
    main_d = load_main_skid ? skid_q : (load_main_in ? in_entry : main_q);
    skid_d = load_skid ? in_entry : skid_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      main_q <= ResetEntry;
      skid_q <= ResetEntry;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign mem_o.valid      = main_v;
  assign mem_o.pc_next    = main_q.pc_next;
  assign mem_o.alu_result = main_q.alu_result;
  assign mem_o.rd2        = main_q.rd2;
  assign mem_o.wr_reg     = main_q.wr_reg;
  assign mem_o.ctrl       = main_v ? main_q.ctrl : '0;

`ifdef EX_MEM_PERF_EN
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d, flush_inc;

  always_comb begin
    flush_inc   = CNT_W'({1'b0, main_v}) + CNT_W'({1'b0, skid_v});
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_v && !mem_o.ready && (stall_cnt_q != CntMax)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_i) begin
      flush_cnt_d = ((CntMax - flush_cnt_q) < flush_inc) ? CntMax : (flush_cnt_q + flush_inc);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: stream, back-pressure, flush, bubble, async reset, perf.
module tb_ex_mem_stage;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 7;
  localparam int unsigned NW = 3;
`ifdef EX_MEM_PERF_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic [NW-1:0] stall_cnt, flush_cnt;
  int n_tests = 0;
  int n_fail  = 0;

  ex_mem_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) ex_bus ();
  ex_mem_stage_if #(.DATA_W(DW), .REG_ADDR_W(AW), .CTRL_W(CW)) mem_bus ();

  ex_mem_stage #(
    .DATA_W    (DW),
    .REG_ADDR_W(AW),
    .CTRL_W    (CW),
    .PC_RESET  (32'd1),
    .CNT_W     (NW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .ex_i       (ex_bus),
    .mem_o      (mem_bus),
    .stall_cnt_o(stall_cnt),
    .flush_cnt_o(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rd2, input logic [6:0] ctrl, input logic [4:0] wr);
    ex_bus.valid      = v;
    ex_bus.pc_next    = pc;
    ex_bus.alu_result = alu;
    ex_bus.rd2        = rd2;
    ex_bus.ctrl       = ctrl;
    ex_bus.wr_reg     = wr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    mem_bus.ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 7'h00, 5'd0);
    #3;
    check("rst_valid", mem_bus.valid, 0);
    check("rst_pc", mem_bus.pc_next, 1);
    check("rst_alu", mem_bus.alu_result, 0);
    check("rst_ctrl", mem_bus.ctrl, 0);
    check("rst_ready", ex_bus.ready, 1);
    check("rst_stall", stall_cnt, 0);
    step();
    rst = 1'b0;

    // Stream
    mem_bus.ready = 1'b1;
    drive(1'b1, 32'h4, 32'h10, 32'h55, 7'h14, 5'd3);
    step();
    check("s1_valid", mem_bus.valid, 1);
    check("s1_alu", mem_bus.alu_result, 32'h10);
    check("s1_wr", mem_bus.wr_reg, 3);
    check("s1_ctrl", mem_bus.ctrl, 7'h14);
    check("s1_ready", ex_bus.ready, 1);
    drive(1'b1, 32'h8, 32'h14, 32'h66, 7'h14, 5'd4);
    step();
    check("s2_alu", mem_bus.alu_result, 32'h14);
    check("s2_ready", ex_bus.ready, 1);
    drive(1'b1, 32'hC, 32'h18, 32'h77, 7'h14, 5'd5);
    step();
    check("s3_alu", mem_bus.alu_result, 32'h18);
    check("s3_pc", mem_bus.pc_next, 32'hC);
    check("s3_rd2", mem_bus.rd2, 32'h77);
    check("s3_ready", ex_bus.ready, 1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 7'h00, 5'd0);
    step();
    check("s_drain_valid", mem_bus.valid, 0);
    check("s_hold_alu", mem_bus.alu_result, 32'h18);

    // Bubble with all control bits set
    drive(1'b0, 32'h0, 32'hDEAD, 32'h0, 7'h7F, 5'd9);
    step();
    check("bub_valid", mem_bus.valid, 0);
    check("bub_ctrl", mem_bus.ctrl, 0);

    // Back-pressure: A, B, C
    mem_bus.ready = 1'b0;
    drive(1'b1, 32'h104, 32'hA0, 32'h1, 7'h08, 5'd1);
    step();
    check("bp_a_alu", mem_bus.alu_result, 32'hA0);
    check("bp_a_ready", ex_bus.ready, 1);
    drive(1'b1, 32'h108, 32'hB0, 32'h2, 7'h12, 5'd2);
    step();
    check("bp_b_ready", ex_bus.ready, 0);
    check("bp_b_alu", mem_bus.alu_result, 32'hA0);
    drive(1'b1, 32'h10C, 32'hC0, 32'h3, 7'h16, 5'd3);
    step();
    check("bp_c_alu", mem_bus.alu_result, 32'hA0);
    check("bp_c_wr", mem_bus.wr_reg, 1);
    check("bp_c_ready", ex_bus.ready, 0);
    mem_bus.ready = 1'b1;
    step();
    check("bp_out_b_alu", mem_bus.alu_result, 32'hB0);
    check("bp_out_b_wr", mem_bus.wr_reg, 2);
    check("bp_out_b_ctrl", mem_bus.ctrl, 7'h12);
    check("bp_out_b_ready", ex_bus.ready, 1);
    step();
    check("bp_out_c_alu", mem_bus.alu_result, 32'hC0);
    check("bp_out_c_wr", mem_bus.wr_reg, 3);
    check("bp_out_c_ctrl", mem_bus.ctrl, 7'h16);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 7'h00, 5'd0);
    step();
    check("bp_drain_valid", mem_bus.valid, 0);
    check("bp_stall", stall_cnt, PerfEn ? 2 : 0);

    // Flush in FULL2 with an incoming entry
    mem_bus.ready = 1'b0;
    drive(1'b1, 32'h200, 32'hD0, 32'h0, 7'h0A, 5'd6);
    step();
    drive(1'b1, 32'h204, 32'hE0, 32'h0, 7'h0A, 5'd7);
    step();
    check("fl_full2_ready", ex_bus.ready, 0);
    drive(1'b1, 32'h208, 32'hF0, 32'h0, 7'h1F, 5'd8);
    flush = 1'b1;
    step();
    check("fl_valid", mem_bus.valid, 0);
    check("fl_ctrl", mem_bus.ctrl, 0);
    check("fl_ready", ex_bus.ready, 1);
    check("fl_cnt", flush_cnt, PerfEn ? 2 : 0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 7'h00, 5'd0);
    step();
    check("fl_no_f", mem_bus.valid, 0);
    drive(1'b1, 32'h20C, 32'h99, 32'h0, 7'h1F, 5'd9);
    flush = 1'b1;
    step();
    check("fl_empty_drop", mem_bus.valid, 0);
    check("fl_stall", stall_cnt, PerfEn ? 4 : 0);
    check("fl_cnt_empty", flush_cnt, PerfEn ? 2 : 0);
    flush = 1'b0;

    // Async reset between edges
    drive(1'b1, 32'h300, 32'hAB, 32'hCD, 7'h1F, 5'd7);
    step();
    check("ar_pre_valid", mem_bus.valid, 1);
    #2 rst = 1'b1;
    #1;
    check("ar_valid", mem_bus.valid, 0);
    check("ar_pc", mem_bus.pc_next, 1);
    check("ar_alu", mem_bus.alu_result, 0);
    check("ar_rd2", mem_bus.rd2, 0);
    check("ar_wr", mem_bus.wr_reg, 0);
    check("ar_ctrl", mem_bus.ctrl, 0);
    check("ar_ready", ex_bus.ready, 1);
    check("ar_stall", stall_cnt, 0);
    check("ar_flush", flush_cnt, 0);
    #1 rst = 1'b0;

    // Perf: stalls and saturation
    drive(1'b1, 32'h400, 32'h44, 32'h0, 7'h08, 5'd4);
    step();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 7'h00, 5'd0);
    repeat (5) step();
    check("pf_valid", mem_bus.valid, 1);
    check("pf_alu", mem_bus.alu_result, 32'h44);
    check("pf_stall5", stall_cnt, PerfEn ? 5 : 0);
    repeat (4) step();
    check("pf_sat", stall_cnt, PerfEn ? 7 : 0);
    mem_bus.ready = 1'b1;
    step();
    check("pf_drain", mem_bus.valid, 0);
    check("pf_sat_hold", stall_cnt, PerfEn ? 7 : 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
